// File: rtl/riscv_test_sequencer.sv
// Run controller for the riscv core: holds it in reset, runs it until a PC self-loop
// or a cycle budget ends the run, then freezes it and streams registers and memory out.
module riscv_test_sequencer #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int MEM_AW       = 7,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 25,
    parameter int HALT_REPEAT  = 3,
    parameter int NUM_REGS     = 8,
    parameter int NUM_MEM      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              core_reset,
    output logic              core_en,
    input  logic [XLEN-1:0]   core_pc,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [XLEN-1:0]   reg_rd_data,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]   mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_is_mem,
    output logic [7:0]        dump_index,
    output logic [XLEN-1:0]   dump_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HOLD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DREG = 3'd3;
    localparam logic [2:0] S_DMEM = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int RPT_W  = $clog2(HALT_REPEAT + 2);

    logic [2:0]        r_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [31:0]       r_cycle_cnt;
    logic              r_timeout;
    logic [XLEN-1:0]   r_prev_pc;
    logic              r_prev_vld;
    logic [RPT_W-1:0]  r_rpt;
    logic [7:0]        r_idx;

    logic [31:0]       w_cnt_next;
    logic [RPT_W-1:0]  w_rpt_next;
    logic              w_halt;
    logic              w_budget;
    logic              w_dump_vld;
    logic              w_last_reg;
    logic              w_last_mem;

    // Repeat counter saturates so a disabled halt detector never wraps back to a match.
    always_comb begin
        w_cnt_next = r_cycle_cnt + 32'd1;
        w_rpt_next = '0;
        if (r_prev_vld && (core_pc == r_prev_pc)) begin
            w_rpt_next = (r_rpt == '1) ? r_rpt : r_rpt + RPT_W'(1);
        end
        w_halt   = (HALT_REPEAT != 0) && (w_rpt_next == RPT_W'(HALT_REPEAT));
        w_budget = (w_cnt_next == 32'(MAX_CYCLES));
    end

    assign w_dump_vld = (r_state == S_DREG) || (r_state == S_DMEM);
    assign w_last_reg = (r_idx == 8'(NUM_REGS - 1));
    assign w_last_mem = (r_idx == 8'(NUM_MEM - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
            r_prev_vld  <= 1'b0;
            r_rpt       <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_HOLD;
                        r_hold_cnt  <= '0;
                        r_cycle_cnt <= '0;
                        r_timeout   <= 1'b0;
                        r_prev_vld  <= 1'b0;
                        r_rpt       <= '0;
                        r_idx       <= '0;
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_next;
                    r_prev_pc   <= core_pc;
                    r_prev_vld  <= 1'b1;
                    r_rpt       <= w_rpt_next;
                    // Halt takes priority when it coincides with the last budgeted cycle.
                    if (w_halt) begin
                        r_state   <= S_DREG;
                        r_timeout <= 1'b0;
                        r_idx     <= '0;
                    end else if (w_budget) begin
                        r_state   <= S_DREG;
                        r_timeout <= 1'b1;
                        r_idx     <= '0;
                    end
                end
                S_DREG: begin
                    if (dump_ready) begin
                        if (w_last_reg) begin
                            r_state <= S_DMEM;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                S_DMEM: begin
                    if (dump_ready) begin
                        if (w_last_mem) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_reset  = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign core_en     = (r_state == S_RUN);
    assign busy        = (r_state == S_HOLD) || (r_state == S_RUN) || w_dump_vld;
    assign done        = (r_state == S_DONE);
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_cnt;

    assign dump_valid  = w_dump_vld;
    assign dump_is_mem = (r_state == S_DMEM);
    assign dump_index  = r_idx;
    assign reg_rd_addr = r_idx[REG_AW-1:0];
    assign mem_rd_addr = r_idx[MEM_AW-1:0];
    assign dump_data   = dump_is_mem ? mem_rd_data : reg_rd_data;

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Randomised bench for riscv_test_sequencer: a fake core replays a PC sequence, and each run
// is compared with the expected exit cycle, timeout flag and register/memory dump order.
module tb_riscv_test_sequencer;

    localparam int XLEN         = 32;
    localparam int REG_AW       = 5;
    localparam int MEM_AW       = 7;
    localparam int RESET_CYCLES = 2;
    localparam int MAX_CYCLES   = 25;
    localparam int HALT_REPEAT  = 3;
    localparam int NUM_REGS     = 8;
    localparam int NUM_MEM      = 8;
    localparam int SEQ_LEN      = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              core_reset;
    logic              core_en;
    logic [XLEN-1:0]   core_pc;
    logic [REG_AW-1:0] reg_rd_addr;
    logic [XLEN-1:0]   reg_rd_data;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic [XLEN-1:0]   mem_rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic              dump_is_mem;
    logic [7:0]        dump_index;
    logic [XLEN-1:0]   dump_data;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [31:0]       cycle_count;

    logic [XLEN-1:0] pc_seq [0:SEQ_LEN-1];
    logic [XLEN-1:0] regs   [0:(1<<REG_AW)-1];
    logic [XLEN-1:0] mem    [0:(1<<MEM_AW)-1];
    int              run_idx;
    int              n_checks = 0;
    int              n_errors = 0;

    always #5 clk = ~clk;

    riscv_test_sequencer #(
        .XLEN(XLEN), .REG_AW(REG_AW), .MEM_AW(MEM_AW), .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .HALT_REPEAT(HALT_REPEAT), .NUM_REGS(NUM_REGS), .NUM_MEM(NUM_MEM)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .core_reset(core_reset), .core_en(core_en),
        .core_pc(core_pc), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_is_mem(dump_is_mem), .dump_index(dump_index),
        .dump_data(dump_data), .busy(busy), .done(done), .timeout(timeout),
        .cycle_count(cycle_count)
    );

    // Fake core: advances one PC-sequence entry per enabled cycle, restarts while held in reset.
    always @(posedge clk) begin
        if (core_reset) run_idx <= 0;
        else if (core_en && run_idx < SEQ_LEN - 1) run_idx <= run_idx + 1;
    end
    assign core_pc     = pc_seq[run_idx];
    assign reg_rd_data = regs[reg_rd_addr];
    assign mem_rd_data = mem[mem_rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected end of run: scan PCs cycle by cycle, counting consecutive unchanged PCs.
    function automatic void model_exit(output int cyc, output bit to);
        int rep = 0;
        cyc = MAX_CYCLES;
        to  = 1'b1;
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            if (k > 1 && pc_seq[k-1] == pc_seq[k-2]) rep++;
            else rep = 0;
            if (HALT_REPEAT != 0 && rep >= HALT_REPEAT) begin
                cyc = k;
                to  = 1'b0;
                return;
            end
        end
    endfunction

    task automatic fill_data(input bit directed);
        for (int i = 0; i < (1 << REG_AW); i++) regs[i] = directed ? 32'h100 + i : $urandom;
        for (int i = 0; i < (1 << MEM_AW); i++) mem[i]  = directed ? 32'hA0 + i  : $urandom;
    endtask

    task automatic seq_increment();
        for (int i = 0; i < SEQ_LEN; i++) pc_seq[i] = 32'(i * 4);
    endtask

    task automatic seq_loop_at(input int last_new);
        for (int i = 0; i < SEQ_LEN; i++) pc_seq[i] = 32'(((i < last_new) ? i : last_new) * 4);
    endtask

    task automatic seq_random();
        int loop_at = $urandom_range(1, 35);
        pc_seq[0] = $urandom & 32'hFFFF_FFFC;
        for (int i = 1; i < SEQ_LEN; i++) begin
            if (i >= loop_at || $urandom_range(0, 9) < 3) pc_seq[i] = pc_seq[i-1];
            else pc_seq[i] = pc_seq[i-1] + 32'd4;
        end
    endtask

    task automatic run_one(input int rmode, input bit poke_start);
        int  exp_cyc;
        bit  exp_to;
        int  seen;
        int  pos;
        int  cyc;
        int  idx;
        bit  is_mem;
        bit  rdy;
        int  total = NUM_REGS + NUM_MEM;
        model_exit(exp_cyc, exp_to);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 1; c <= RESET_CYCLES; c++) begin
            chk("hold_core_reset", core_reset, 1);
            chk("hold_core_en", core_en, 0);
            chk("hold_busy", busy, 1);
            if (c == 1) begin
                chk("hold_cycle_count", cycle_count, 0);
                chk("hold_timeout", timeout, 0);
                chk("hold_done", done, 0);
            end
            @(negedge clk);
        end
        chk("run_core_reset", core_reset, 0);
        seen = 0;
        while (core_en === 1'b1 && seen < MAX_CYCLES + 4) begin
            seen++;
            start = (poke_start && seen == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_cycles", 64'(seen), 64'(exp_cyc));
        chk("cycle_count", cycle_count, 64'(exp_cyc));
        chk("timeout", timeout, 64'(exp_to));
        chk("dump_core_reset", core_reset, 0);
        chk("dump_core_en", core_en, 0);
        pos = 0;
        cyc = 0;
        while (pos < total && cyc < 400) begin
            is_mem = (pos >= NUM_REGS);
            idx    = is_mem ? pos - NUM_REGS : pos;
            chk("dump_valid", dump_valid, 1);
            chk("dump_busy", busy, 1);
            chk("dump_is_mem", dump_is_mem, 64'(is_mem));
            chk("dump_index", dump_index, 64'(idx));
            if (is_mem) begin
                chk("mem_rd_addr", mem_rd_addr, 64'(idx));
                chk("dump_data_mem", dump_data, mem[idx]);
            end else begin
                chk("reg_rd_addr", reg_rd_addr, 64'(idx));
                chk("dump_data_reg", dump_data, regs[idx]);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dump_ready = rdy;
            if (dump_valid && rdy) pos++;
            @(negedge clk);
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_words", 64'(pos), 64'(total));
        if (rmode == 0) chk("dump_no_gaps", 64'(cyc), 64'(total));
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", dump_valid, 0);
        chk("done_core_reset", core_reset, 0);
        chk("done_core_en", core_en, 0);
        chk("done_cycle_count", cycle_count, 64'(exp_cyc));
        chk("done_timeout", timeout, 64'(exp_to));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        dump_ready = 1'b0;
        seq_increment();
        fill_data(1'b1);
        repeat (2) @(negedge clk);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_dump_index", dump_index, 0);
        chk("rst_dump_is_mem", dump_is_mem, 0);
        chk("rst_reg_addr", reg_rd_addr, 0);
        chk("rst_mem_addr", mem_rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // Halt after three repeats of 0x0C: seven RUN cycles.
        pc_seq[0] = 32'h00; pc_seq[1] = 32'h04; pc_seq[2] = 32'h08;
        for (int i = 3; i < SEQ_LEN; i++) pc_seq[i] = 32'h0C;
        run_one(0, 1'b0);

        seq_increment();
        run_one(1, 1'b1);
        run_one(1, 1'b0);

        // Third repeat lands exactly on the last budgeted cycle.
        seq_loop_at(21);
        fill_data(1'b0);
        run_one(2, 1'b1);

        // Reset in the middle of a run.
        seq_increment();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (RESET_CYCLES + 4) @(negedge clk);
        chk("midrun_core_en", core_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_core_reset", core_reset, 1);
        chk("midrst_core_en", core_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_cycle_count", cycle_count, 0);
        @(negedge clk);
        chk("midrst_idle", busy, 0);

        for (int r = 0; r < 10; r++) begin
            seq_random();
            fill_data(1'b0);
            run_one($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
